issue_queue: RTL
================

Name: issue_queue

Overview:
- Dual-ported instruction queue between decode and the issue-dispatch stage.
- Accepts 0–2 decoded PC_set entries per cycle from decode.
- Presents the two oldest entries to dispatch as o_set1/o_set2 with per-slot valid bits.
- Retires 0–2 entries per cycle according to the issue count dispatch returns. Absorbs issue-side interlock stalls so decode does not have to stall on every single-issue cycle.

Parameters:
- DEPTH, 8, number of entries; power of 2, minimum 4.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rstn, input, 1, asynchronous active-low reset.
- flush, input, 1, discard all queued entries (branch mispredict/exception).
- i_stall, input, 1, back-end stall; when high, no entries retire this cycle.
- i_set1, input, PC_set, older incoming instruction from decode.
- i_set2, input, PC_set, younger incoming instruction from decode.
- i_in_valid, input, 2, bit1 = i_set1 valid, bit0 = i_set2 valid.
- o_ready, output, 1, queue can accept two entries this cycle.
- o_set1, output, PC_set, head entry (oldest).
- o_set2, output, PC_set, head+1 entry.
- o_is_valid, output, 2, bit1 = o_set1 valid, bit0 = o_set2 valid.
- i_usingNUM, input, 2, entries issued by dispatch this cycle (0, 1 or 2).
- o_count, output, CNT_W, current occupancy.

Behaviour:
- Circular buffer with head pointer, tail pointer (log2(DEPTH) bits, natural wrap) and count register. Storage entries are not reset.
- Reset (rstn low, asynchronous): head=0, tail=0, count=0 → o_is_valid=2'b00, o_count=0, o_ready=1. Reset asserted mid-operation drops all contents immediately.
- o_ready = (count <= DEPTH-2), computed from the registered count only. Reaching full never depends on same-cycle pops.
- Push happens only when o_ready=1:
  - 2'b11: write i_set1 at tail and i_set2 at tail+1; push=2.
  - 2'b10: write i_set1 at tail; push=1.
  - 2'b01: write i_set2 at tail (compacted); push=1.
  - 2'b00: no push.
- When o_ready=0, input is ignored. Decode must hold its data, so there is no loss.
- Outputs are combinational reads of head and head+1 (wrapping). o_is_valid = {count>=1, count>=2}.
- The o_valid field inside o_set1/o_set2 is overridden with o_is_valid[1]/[0]; all other fields are passed through unchanged.
- Pop: pop = i_stall ? 0 : min(i_usingNUM, count). i_usingNUM=3 is treated as 2. Dispatch cannot retire entries that are not presented.
- Next state:
  - head += pop
  - tail += push
  - count = count + push − pop
- Pushes and pops in the same cycle are legal, including when count=DEPTH-2 with push=2 and pop=2.
- Zero bypass: an entry pushed in cycle N is first visible on o_set* in cycle N+1. Minimum latency is 1 cycle.
- Full (count=DEPTH): o_ready=0. Popping 1 while full makes o_ready=0 still, since DEPTH-1 > DEPTH-2. Popping 2 makes o_ready=1 next cycle.
- Empty: o_is_valid=00; i_usingNUM is ignored.
- flush has priority over push, pop and i_stall. Next cycle head=tail=0, count=0, o_is_valid=00. Inputs in the flush cycle are discarded.
- Ordering invariant: o_set1 is always strictly older than o_set2. Program order is preserved across wrap-around.

Optional Feature:
- ISSUE_QUEUE_PERF_EN defined: adds three 32-bit output ports, each reset to 0, saturating at 32'hFFFF_FFFF, and cleared by rstn only (not by flush):
  - o_perf_full_cyc: increments each cycle o_ready=0.
  - o_perf_empty_cyc: increments each cycle count=0 and not flush.
  - o_perf_dual_cyc: increments each cycle pop=2.
- Not defined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset then push 2'b11 (PC 0x1c000000/0x1c000004): next cycle o_is_valid=11, o_set1.PC=0x1c000000, o_set2.PC=0x1c000004, o_count=2.
- Push 2'b11 for 4 consecutive cycles with i_usingNUM=0 (DEPTH=8): o_count=8, o_ready=0. A fifth push with new PCs leaves contents unchanged. Then i_usingNUM=2 → o_count=6, o_ready=1.
- Push 2'b01 only (PC 0x1c000010): entry lands in slot 1; next cycle o_is_valid=10, o_set1.PC=0x1c000010.
- count=1, i_usingNUM=2 → pop clamped to 1; next cycle o_count=0, o_is_valid=00, head advanced by 1.
- Wrap-around: drive 20 sequential PCs with alternating i_usingNUM 1/2. The order of o_set1.PC retirements equals the push order, with no duplicates or gaps.
- count=5, i_stall=1, i_usingNUM=2, push 2'b11 → o_count=7. Then flush=1 with push 2'b11 → next cycle o_count=0, o_is_valid=00, o_ready=1.

Source files
------------

// File: rtl/issue_queue.sv
// issue_queue: dual-ported circular instruction queue between decode and
// issue dispatch. Accepts up to two entries per cycle, presents the two oldest
// entries, and retires up to two entries per cycle as dispatch reports.
// Optional build macro: ISSUE_QUEUE_PERF_EN adds saturating performance
// counters (full cycles, empty cycles, dual-retire cycles).

typedef struct packed {
  logic        o_valid;
  logic [31:0] PC;
  logic [31:0] inst;
} PC_set;

module issue_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             i_stall,
  input  PC_set            i_set1,
  input  PC_set            i_set2,
  input  logic [1:0]       i_in_valid,
  output logic             o_ready,
  output PC_set            o_set1,
  output PC_set            o_set2,
  output logic [1:0]       o_is_valid,
  input  logic [1:0]       i_usingNUM,
  output logic [CNT_W-1:0] o_count
`ifdef ISSUE_QUEUE_PERF_EN
  ,
  output logic [31:0]      o_perf_full_cyc,
  output logic [31:0]      o_perf_empty_cyc,
  output logic [31:0]      o_perf_dual_cyc
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  PC_set            mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [CNT_W-1:0] count;
  logic [1:0]       use_num;
  logic [1:0]       push_num;
  logic [1:0]       pop_num;

  // Occupancy-derived status, clamped pop/push amounts and head reads.
  always_comb begin
    head_p1    = head + PTR_W'(1);
    tail_p1    = tail + PTR_W'(1);
    o_count    = count;
    o_ready    = (count <= CNT_W'(DEPTH - 2));
    o_is_valid = {count != '0, count >= CNT_W'(2)};
    use_num    = (i_usingNUM == 2'd3) ? 2'd2 : i_usingNUM;
    pop_num    = 2'd0;
    push_num   = 2'd0;
    if (!flush && !i_stall) begin
      if (CNT_W'(use_num) > count) pop_num = count[1:0];
      else                         pop_num = use_num;
    end
    if (!flush && o_ready) begin
      push_num = {1'b0, i_in_valid[1]} + {1'b0, i_in_valid[0]};
    end
    o_set1         = mem[head];
    o_set1.o_valid = o_is_valid[1];
    o_set2         = mem[head_p1];
    o_set2.o_valid = o_is_valid[0];
  end

  // Pointer and occupancy registers; flush empties the queue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_num);
      tail  <= tail + PTR_W'(push_num);
      count <= count + CNT_W'(push_num) - CNT_W'(pop_num);
    end
  end

  // Entry storage, written compacted at the tail; contents are not reset.
  always_ff @(posedge clk) begin
    if (!flush && o_ready) begin
      case (i_in_valid)
        2'b11: begin
          mem[tail]    <= i_set1;
          mem[tail_p1] <= i_set2;
        end
        2'b10:   mem[tail] <= i_set1;
        2'b01:   mem[tail] <= i_set2;
        default: ;
      endcase
    end
  end

`ifdef ISSUE_QUEUE_PERF_EN
  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_perf_full_cyc  <= '0;
      o_perf_empty_cyc <= '0;
      o_perf_dual_cyc  <= '0;
    end else begin
      if (!o_ready && o_perf_full_cyc != '1)
        o_perf_full_cyc <= o_perf_full_cyc + 32'd1;
      if (count == '0 && !flush && o_perf_empty_cyc != '1)
        o_perf_empty_cyc <= o_perf_empty_cyc + 32'd1;
      if (pop_num == 2'd2 && o_perf_dual_cyc != '1)
        o_perf_dual_cyc <= o_perf_dual_cyc + 32'd1;
    end
  end
`endif

endmodule
